// File: rtl/bus_debug_master.sv
// Byte-stream debug bus master: decodes 'W'/'R' commands from a byte stream,
// issues one word transaction on the valid/ready memory bus and streams back the result.
module bus_debug_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [7:0]  rsp_data,
    input  logic        rsp_ready,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [7:0] OP_W    = 8'h57;
    localparam logic [7:0] OP_R    = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h54;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          mem_valid_q, mem_valid_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic [23:0]   rsp_buf_q, rsp_buf_d;
    logic [1:0]    rsp_left_q, rsp_left_d;

    logic          cmd_fire;
    logic [31:0]   addr_nx;
    logic [31:0]   wdata_nx;

    assign cmd_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign cmd_fire  = cmd_valid && cmd_ready;
    // Little-endian fields: each new byte enters at the top and moves down.
    assign addr_nx   = {cmd_data, addr_q[31:8]};
    assign wdata_nx  = {cmd_data, wdata_q[31:8]};

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        byte_cnt_d  = byte_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        to_cnt_d    = to_cnt_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_buf_d   = rsp_buf_q;
        rsp_left_d  = rsp_left_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    if ((cmd_data == OP_W) || (cmd_data == OP_R)) begin
                        is_wr_d    = (cmd_data == OP_W);
                        byte_cnt_d = 2'd0;
                        state_d    = S_ADDR;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = RSP_ERR;
                        rsp_left_d  = 2'd0;
                        state_d     = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (cmd_fire) begin
                    addr_d     = addr_nx;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            mem_valid_d = 1'b1;
                            mem_addr_d  = {addr_nx[31:2], 2'b00};
                            mem_wstrb_d = 4'b0000;
                            to_cnt_d    = '0;
                            state_d     = S_BUS;
                        end
                    end
                end
            end
            S_DATA: begin
                if (cmd_fire) begin
                    wdata_d    = wdata_nx;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {addr_q[31:2], 2'b00};
                        mem_wdata_d = wdata_nx;
                        mem_wstrb_d = 4'b1111;
                        to_cnt_d    = '0;
                        state_d     = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // A completion in the same cycle as the timeout still counts as a completion.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                    if (is_wr_q) begin
                        rsp_data_d = RSP_OK;
                        rsp_left_d = 2'd0;
                    end else begin
                        rsp_data_d = mem_rdata[7:0];
                        rsp_buf_d  = mem_rdata[31:8];
                        rsp_left_d = 2'd3;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = RSP_TO;
                    rsp_left_d  = 2'd0;
                    state_d     = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (rsp_left_q == 2'd0) begin
                        rsp_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        rsp_data_d = rsp_buf_q[7:0];
                        rsp_buf_d  = {8'h00, rsp_buf_q[23:8]};
                        rsp_left_d = rsp_left_q - 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            is_wr_q     <= 1'b0;
            byte_cnt_q  <= 2'd0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            to_cnt_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_buf_q   <= 24'h0;
            rsp_left_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            byte_cnt_q  <= byte_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            to_cnt_q    <= to_cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_buf_q   <= rsp_buf_d;
            rsp_left_q  <= rsp_left_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_debug_master.sv
// Bench for bus_debug_master: command vectors, bus responder model and a response scoreboard.
module tb_bus_debug_master;

    localparam int TO = 8;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_ready;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;

    bus_debug_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;     // responder delay in cycles, 0 = never responds
        logic [31:0] exp_addr;
        logic [31:0] exp_rsp;   // expected response bytes, LSB first
        int          exp_n;
        logic        exp_bus;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_wdata;
    } bus_t;

    logic [7:0] exp_q[$];
    bus_t       bus_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         resp_delay = 0;
    logic [31:0] resp_rdata = 32'h0;
    int         last_dur = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus responder: checks each request, holds it, answers after resp_delay cycles.
    initial begin
        int cyc;
        bus_t b;
        logic [31:0] h_addr, h_wdata;
        logic [3:0]  h_wstrb;
        cyc = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        h_addr = 32'h0; h_wdata = 32'h0; h_wstrb = 4'h0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                check("mem_valid after ready", {31'h0, mem_valid}, 32'h0);
            end
            if (mem_valid) begin
                if (cyc == 0) begin
                    if (bus_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected bus request: addr 0x%08h, expected none", mem_addr);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus addr", mem_addr, b.addr);
                        check("bus wstrb", {28'h0, mem_wstrb}, {28'h0, b.wstrb});
                        if (b.chk_wdata) check("bus wdata", mem_wdata, b.wdata);
                    end
                    h_addr = mem_addr; h_wdata = mem_wdata; h_wstrb = mem_wstrb;
                end else begin
                    check("bus hold addr", mem_addr, h_addr);
                    check("bus hold wdata", mem_wdata, h_wdata);
                    check("bus hold wstrb", {28'h0, mem_wstrb}, {28'h0, h_wstrb});
                end
                cyc++;
                if (resp_delay != 0 && cyc == resp_delay) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_rdata;
                end
            end else if (cyc != 0) begin
                last_dur = cyc;
                cyc = 0;
            end
        end
    end

    // Response monitor / scoreboard
    initial begin
        logic prev_pend;
        logic [7:0] prev_data, e;
        prev_pend = 1'b0;
        prev_data = 8'h0;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_valid && prev_pend) check("rsp stable", {24'h0, rsp_data}, {24'h0, prev_data});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp extra byte: got 0x%02h, expected none", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp byte", {24'h0, rsp_data}, {24'h0, e});
                end
            end
            prev_pend = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
        end
    end

    // Driver tasks (called on a negedge, return on a negedge)
    task automatic send_byte(input logic [7:0] b);
        int n;
        cmd_valid = 1'b1;
        cmd_data  = b;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_ready timeout: got 0, expected 1");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic issue_cmd(input vec_t v);
        bus_t b;
        resp_delay = v.delay;
        resp_rdata = v.rdata;
        if (v.exp_bus) begin
            b.addr      = v.exp_addr;
            b.wdata     = v.wdata;
            b.wstrb     = (v.op == OP_W) ? 4'b1111 : 4'b0000;
            b.chk_wdata = (v.op == OP_W);
            bus_q.push_back(b);
        end
        for (int k = 0; k < v.exp_n; k++) exp_q.push_back(v.exp_rsp[8*k +: 8]);
        send_byte(v.op);
        if (v.op == OP_W || v.op == OP_R)
            for (int k = 0; k < 4; k++) send_byte(v.addr[8*k +: 8]);
        if (v.op == OP_W)
            for (int k = 0; k < 4; k++) send_byte(v.wdata[8*k +: 8]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 500);
        if (exp_q.size() != 0 || busy) begin
            n_checks++; n_fail++;
            $display("FAIL %s done timeout: got %0d bytes pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_cmd(input vec_t v, input string name);
        int exp_dur;
        last_dur = 0;
        issue_cmd(v);
        wait_done(name);
        if (v.exp_bus) begin
            exp_dur = (v.delay == 0 || v.delay > TO) ? TO : v.delay;
            check({name, " valid cycles"}, last_dur, exp_dur);
        end
    endtask

    vec_t vecs[9];
    vec_t v;

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rsp_ready = 1'b1;
        #13;
        check("reset mem_valid", {31'h0, mem_valid}, 32'h0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_wdata", mem_wdata, 32'h0);
        check("reset mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset rsp_data", {24'h0, rsp_data}, 32'h0);
        check("reset busy", {31'h0, busy}, 32'h0);
        check("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        vecs[0] = '{op:OP_W, addr:32'h0000_0100, wdata:32'hDEAD_BEEF, rdata:32'h0, delay:3,
                    exp_addr:32'h0000_0100, exp_rsp:32'h4B, exp_n:1, exp_bus:1'b1};
        vecs[1] = '{op:OP_R, addr:32'h0000_0100, wdata:32'h0, rdata:32'hDEAD_BEEF, delay:4,
                    exp_addr:32'h0000_0100, exp_rsp:32'hDEAD_BEEF, exp_n:4, exp_bus:1'b1};
        vecs[2] = '{op:OP_W, addr:32'h0000_0103, wdata:32'h1234_5678, rdata:32'h0, delay:1,
                    exp_addr:32'h0000_0100, exp_rsp:32'h4B, exp_n:1, exp_bus:1'b1};
        vecs[3] = '{op:8'h41, addr:32'h0, wdata:32'h0, rdata:32'h0, delay:1,
                    exp_addr:32'h0, exp_rsp:32'h3F, exp_n:1, exp_bus:1'b0};
        vecs[4] = '{op:OP_R, addr:32'hF000_1000, wdata:32'h0, rdata:32'h0000_00A5, delay:2,
                    exp_addr:32'hF000_1000, exp_rsp:32'h0000_00A5, exp_n:4, exp_bus:1'b1};
        vecs[5] = '{op:OP_W, addr:32'hF000_0002, wdata:32'h0000_0055, rdata:32'h0, delay:1,
                    exp_addr:32'hF000_0000, exp_rsp:32'h4B, exp_n:1, exp_bus:1'b1};
        vecs[6] = '{op:OP_R, addr:32'h0000_0200, wdata:32'h0, rdata:32'hCAFE_F00D, delay:8,
                    exp_addr:32'h0000_0200, exp_rsp:32'hCAFE_F00D, exp_n:4, exp_bus:1'b1};
        vecs[7] = '{op:OP_R, addr:32'h0000_0204, wdata:32'h0, rdata:32'h0, delay:0,
                    exp_addr:32'h0000_0204, exp_rsp:32'h54, exp_n:1, exp_bus:1'b1};
        vecs[8] = '{op:OP_W, addr:32'h0000_0300, wdata:32'h0BAD_F00D, rdata:32'h0, delay:0,
                    exp_addr:32'h0000_0300, exp_rsp:32'h54, exp_n:1, exp_bus:1'b1};

        for (int i = 0; i < 9; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            v.op       = ($urandom_range(0, 1) == 1) ? OP_W : OP_R;
            v.addr     = $urandom;
            v.wdata    = $urandom;
            v.rdata    = $urandom;
            v.delay    = $urandom_range(1, 7);
            v.exp_addr = {v.addr[31:2], 2'b00};
            v.exp_bus  = 1'b1;
            v.exp_rsp  = (v.op == OP_W) ? 32'h4B : v.rdata;
            v.exp_n    = (v.op == OP_W) ? 1 : 4;
            run_cmd(v, $sformatf("rand%0d", i));
        end

        // Response backpressure with a command byte waiting upstream
        rsp_ready = 1'b0;
        v = '{op:OP_R, addr:32'h0000_0100, wdata:32'h0, rdata:32'hDEAD_BEEF, delay:4,
              exp_addr:32'h0000_0100, exp_rsp:32'hDEAD_BEEF, exp_n:4, exp_bus:1'b1};
        issue_cmd(v);
        exp_q.push_back(8'h3F);
        for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clk);
        check("bp rsp_valid", {31'h0, rsp_valid}, 32'h1);
        cmd_valid = 1'b1;
        cmd_data  = 8'h41;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp cmd_ready", {31'h0, cmd_ready}, 32'h0);
            check("bp rsp_data", {24'h0, rsp_data}, 32'h0000_00EF);
        end
        rsp_ready = 1'b1;
        send_byte(8'h41);
        wait_done("backpressure");

        // Reset while waiting on the bus
        v = '{op:OP_R, addr:32'h0000_0400, wdata:32'h0, rdata:32'h0, delay:0,
              exp_addr:32'h0000_0400, exp_rsp:32'h0, exp_n:0, exp_bus:1'b1};
        issue_cmd(v);
        repeat (3) @(negedge clk);
        check("pre-reset mem_valid", {31'h0, mem_valid}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("bus reset mem_valid", {31'h0, mem_valid}, 32'h0);
        check("bus reset busy", {31'h0, busy}, 32'h0);
        check("bus reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of the data field, then a full write
        send_byte(OP_W);
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k));
        send_byte(8'h77);
        send_byte(8'h66);
        check("pre-reset busy", {31'h0, busy}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("data reset busy", {31'h0, busy}, 32'h0);
        check("data reset mem_valid", {31'h0, mem_valid}, 32'h0);
        check("data reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        v = '{op:OP_W, addr:32'h0000_0500, wdata:32'hA5A5_5A5A, rdata:32'h0, delay:2,
              exp_addr:32'h0000_0500, exp_rsp:32'h4B, exp_n:1, exp_bus:1'b1};
        run_cmd(v, "post-reset write");

        repeat (3) @(negedge clk);
        check("leftover rsp bytes", exp_q.size(), 0);
        check("leftover bus requests", bus_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
